// File: rtl/addr_seq.sv
// rtl/addr_seq.sv - 65C02 address-bus sequencer driving ABL/ABH selects and PC strobes.
// Define PAGE_PENALTY_EN to take an extra FIX cycle when an indexed address crosses a page.
module addr_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic       rdy,
  input  logic       abl_co,
  output logic [2:0] abh_op,
  output logic       abh_ci,
  output logic       abh_ff,
  output logic [2:0] abl_sel,
  output logic       idx_y,
  output logic       opl_ld,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE, S_OPH, S_P0, S_P1, S_ADR, S_FIX, S_IB, S_V0, S_V1, S_LD, S_NOP
  } state_t;

  localparam logic [2:0] M_ZP      = 3'd0;
  localparam logic [2:0] M_ABS     = 3'd1;
  localparam logic [2:0] M_ABS_X   = 3'd2;
  localparam logic [2:0] M_IND_Y   = 3'd3;
  localparam logic [2:0] M_JMP_IND = 3'd4;
  localparam logic [2:0] M_VECTOR  = 3'd5;

  localparam logic [2:0] ABL_HOLD = 3'd0;
  localparam logic [2:0] ABL_INC  = 3'd1;
  localparam logic [2:0] ABL_DB   = 3'd2;
  localparam logic [2:0] ABL_OPL  = 3'd3;
  localparam logic [2:0] ABL_IDX  = 3'd4;
  localparam logic [2:0] ABL_PCL  = 3'd5;
  localparam logic [2:0] ABL_VEC  = 3'd6;

  localparam logic [2:0] ABH_ZERO = 3'b000;
  localparam logic [2:0] ABH_ABH  = 3'b100;
  localparam logic [2:0] ABH_PCH  = 3'b110;
  localparam logic [2:0] ABH_DB   = 3'b111;

  state_t     state, state_n;
  logic [2:0] mode_q, mode_n;
  logic       last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mode_q <= 3'd0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
    end
  end

  // Nothing advances while memory is not ready, including acceptance of start.
  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    last    = 1'b0;
    if (rdy) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_n = mode;
            case (mode)
              M_ZP:                        state_n = S_ADR;
              M_ABS, M_ABS_X, M_JMP_IND:   state_n = S_OPH;
              M_IND_Y:                     state_n = S_P0;
              M_VECTOR:                    state_n = S_V0;
              default:                     state_n = S_NOP;
            endcase
          end
        end
        S_OPH: state_n = S_ADR;
        S_P0:  state_n = S_P1;
        S_P1:  state_n = S_ADR;
        S_ADR: begin
          case (mode_q)
            M_JMP_IND: state_n = S_IB;
            M_ABS_X, M_IND_Y: begin
`ifdef PAGE_PENALTY_EN
              if (abl_co) begin
                state_n = S_FIX;
              end else begin
                state_n = S_IDLE;
                last    = 1'b1;
              end
`else
              state_n = S_IDLE;
              last    = 1'b1;
`endif
            end
            default: begin
              state_n = S_IDLE;
              last    = 1'b1;
            end
          endcase
        end
        S_FIX: begin
          state_n = S_IDLE;
          last    = 1'b1;
        end
        S_IB:  state_n = S_LD;
        S_V0:  state_n = S_V1;
        S_V1:  state_n = S_LD;
        S_LD: begin
          state_n = S_IDLE;
          last    = 1'b1;
        end
        S_NOP: begin
          state_n = S_IDLE;
          last    = 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    abl_sel = ABL_HOLD;
    abh_op  = ABH_ZERO;
    abh_ci  = 1'b0;
    abh_ff  = 1'b0;
    opl_ld  = 1'b0;
    ld_pc   = 1'b0;
    inc_pc  = 1'b0;
    done    = last;
    busy    = (state != S_IDLE);
    idx_y   = (mode_q == M_IND_Y);
    case (state)
      S_IDLE, S_NOP: begin
        abl_sel = ABL_PCL;
        abh_op  = ABH_PCH;
      end
      S_OPH: begin
        abl_sel = ABL_INC;
        abh_op  = ABH_ABH;
        abh_ci  = abl_co;
        opl_ld  = 1'b1;
        inc_pc  = 1'b1;
      end
      S_P0: abl_sel = ABL_DB;
      S_P1: begin
        // High byte stays 00 so the pointer fetch wraps within zero page.
        abl_sel = ABL_INC;
        opl_ld  = 1'b1;
      end
      S_ADR: begin
        case (mode_q)
          M_ABS, M_JMP_IND: begin
            abl_sel = ABL_OPL;
            abh_op  = ABH_DB;
          end
          M_ABS_X, M_IND_Y: begin
            abl_sel = ABL_IDX;
            abh_op  = ABH_DB;
`ifdef PAGE_PENALTY_EN
            abh_ci  = 1'b0;
`else
            abh_ci  = abl_co;
`endif
          end
          default: abl_sel = ABL_DB;
        endcase
      end
      S_FIX: begin
        abl_sel = ABL_HOLD;
        abh_op  = ABH_ABH;
        abh_ci  = 1'b1;
      end
      S_IB: begin
        // Carry propagates into ABH, so the indirect pointer never wraps its page.
        abl_sel = ABL_INC;
        abh_op  = ABH_ABH;
        abh_ci  = abl_co;
        opl_ld  = 1'b1;
      end
      S_V0: begin
        abl_sel = ABL_VEC;
        abh_ff  = 1'b1;
      end
      S_V1: begin
        abl_sel = ABL_INC;
        abh_ff  = 1'b1;
        opl_ld  = 1'b1;
      end
      S_LD: begin
        abl_sel = ABL_OPL;
        abh_op  = ABH_DB;
        ld_pc   = 1'b1;
      end
      default: begin
        abl_sel = ABL_PCL;
        abh_op  = ABH_PCH;
      end
    endcase
    // Stall: freeze the bus and suppress every side-effect strobe.
    if (!rdy && state != S_IDLE) begin
      abl_sel = ABL_HOLD;
      abh_op  = ABH_ABH;
      abh_ci  = 1'b0;
      abh_ff  = (state == S_V0) || (state == S_V1);
      opl_ld  = 1'b0;
      ld_pc   = 1'b0;
      inc_pc  = 1'b0;
      done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_addr_seq.sv
// tb/tb_addr_seq.sv - directed scoreboard bench for addr_seq.
module tb_addr_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, rdy, abl_co;
  logic [2:0] mode;
  logic [2:0] abh_op, abl_sel;
  logic       abh_ci, abh_ff, idx_y, opl_ld, ld_pc, inc_pc, busy, done;

  int checks = 0;
  int passed = 0;
  logic [13:0] sb[$];
  logic [13:0] obs;

  addr_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rdy(rdy), .abl_co(abl_co),
    .abh_op(abh_op), .abh_ci(abh_ci), .abh_ff(abh_ff), .abl_sel(abl_sel), .idx_y(idx_y),
    .opl_ld(opl_ld), .ld_pc(ld_pc), .inc_pc(inc_pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign obs = {abh_op, abh_ci, abh_ff, abl_sel, idx_y, opl_ld, ld_pc, inc_pc, busy, done};

  function automatic logic [13:0] ov(input logic [2:0] op, input logic ci, input logic ff,
                                     input logic [2:0] sel, input logic y, input logic opl,
                                     input logic ld, input logic inc, input logic bsy,
                                     input logic dn);
    return {op, ci, ff, sel, y, opl, ld, inc, bsy, dn};
  endfunction

  function automatic logic [13:0] idle_v(input logic y);
    return ov(3'b110, 0, 0, 3'd5, y, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string tag);
    logic [13:0] e;
    checks++;
    if (sb.size() == 0) begin
      $error("FAIL %s observed=%b expected=<scoreboard empty>", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) passed++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic cyc(input logic s, input logic [2:0] m, input logic r, input logic co,
                     input string tag);
    @(posedge clk);
    #1;
    start  = s;
    mode   = m;
    rdy    = r;
    abl_co = co;
    @(negedge clk);
    chk(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 3'd0; rdy = 1'b1; abl_co = 1'b0;
    #2;
    sb.push_back(idle_v(0));
    chk("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ZP; start on the done cycle must be ignored
    sb.push_back(idle_v(0));
    sb.push_back(ov(3'b000, 0, 0, 3'd2, 0, 0, 0, 0, 1, 1));
    sb.push_back(idle_v(0));
    cyc(1, 3'd0, 1, 0, "zp_start");
    cyc(1, 3'd1, 1, 0, "zp_adr");
    cyc(0, 3'd0, 1, 0, "zp_idle");

    // ABS_X with carry out of ABL in ADR
    sb.push_back(idle_v(0));
    sb.push_back(ov(3'b100, 0, 0, 3'd1, 0, 1, 0, 1, 1, 0));
`ifdef PAGE_PENALTY_EN
    sb.push_back(ov(3'b111, 0, 0, 3'd4, 0, 0, 0, 0, 1, 0));
    sb.push_back(ov(3'b100, 1, 0, 3'd0, 0, 0, 0, 0, 1, 1));
`else
    sb.push_back(ov(3'b111, 1, 0, 3'd4, 0, 0, 0, 0, 1, 1));
`endif
    sb.push_back(idle_v(0));
    cyc(1, 3'd2, 1, 0, "absx_start");
    cyc(0, 3'd2, 1, 0, "absx_oph");
    cyc(0, 3'd2, 1, 1, "absx_adr");
`ifdef PAGE_PENALTY_EN
    cyc(0, 3'd2, 1, 1, "absx_fix");
`endif
    cyc(0, 3'd2, 1, 0, "absx_idle");

    // JMP_IND; carry into OPH exercised with abl_co=1
    sb.push_back(idle_v(0));
    sb.push_back(ov(3'b100, 1, 0, 3'd1, 0, 1, 0, 1, 1, 0));
    sb.push_back(ov(3'b111, 0, 0, 3'd3, 0, 0, 0, 0, 1, 0));
    sb.push_back(ov(3'b100, 0, 0, 3'd1, 0, 1, 0, 0, 1, 0));
    sb.push_back(ov(3'b111, 0, 0, 3'd3, 0, 0, 1, 0, 1, 1));
    sb.push_back(idle_v(0));
    cyc(1, 3'd4, 1, 0, "jmp_start");
    cyc(0, 3'd4, 1, 1, "jmp_oph");
    cyc(0, 3'd4, 1, 0, "jmp_adr");
    cyc(0, 3'd4, 1, 0, "jmp_ib");
    cyc(0, 3'd4, 1, 0, "jmp_ld");
    cyc(0, 3'd4, 1, 0, "jmp_idle");

    // VECTOR
    sb.push_back(idle_v(0));
    sb.push_back(ov(3'b000, 0, 1, 3'd6, 0, 0, 0, 0, 1, 0));
    sb.push_back(ov(3'b000, 0, 1, 3'd1, 0, 1, 0, 0, 1, 0));
    sb.push_back(ov(3'b111, 0, 0, 3'd3, 0, 0, 1, 0, 1, 1));
    sb.push_back(idle_v(0));
    cyc(1, 3'd5, 1, 0, "vec_start");
    cyc(0, 3'd5, 1, 0, "vec_v0");
    cyc(0, 3'd5, 1, 0, "vec_v1");
    cyc(0, 3'd5, 1, 0, "vec_ld");
    cyc(0, 3'd5, 1, 0, "vec_idle");

    // IND_Y, start while busy ignored, two stall cycles in P1
    sb.push_back(idle_v(0));
    sb.push_back(ov(3'b000, 0, 0, 3'd2, 1, 0, 0, 0, 1, 0));
    sb.push_back(ov(3'b100, 0, 0, 3'd0, 1, 0, 0, 0, 1, 0));
    sb.push_back(ov(3'b100, 0, 0, 3'd0, 1, 0, 0, 0, 1, 0));
    sb.push_back(ov(3'b000, 0, 0, 3'd1, 1, 1, 0, 0, 1, 0));
    sb.push_back(ov(3'b111, 0, 0, 3'd4, 1, 0, 0, 0, 1, 1));
    sb.push_back(idle_v(1));
    cyc(1, 3'd3, 1, 0, "indy_start");
    cyc(1, 3'd0, 1, 0, "indy_p0");
    cyc(0, 3'd0, 0, 0, "indy_stall1");
    cyc(0, 3'd0, 0, 0, "indy_stall2");
    cyc(0, 3'd0, 1, 0, "indy_p1");
    cyc(0, 3'd0, 1, 0, "indy_adr");
    cyc(0, 3'd0, 1, 0, "indy_idle");

    // IND_Y aborted by asynchronous reset in P1
    sb.push_back(idle_v(1));
    sb.push_back(ov(3'b000, 0, 0, 3'd2, 1, 0, 0, 0, 1, 0));
    sb.push_back(ov(3'b000, 0, 0, 3'd1, 1, 1, 0, 0, 1, 0));
    sb.push_back(idle_v(0));
    sb.push_back(idle_v(0));
    cyc(1, 3'd3, 1, 0, "rst_start");
    cyc(0, 3'd3, 1, 0, "rst_p0");
    cyc(0, 3'd3, 1, 0, "rst_p1");
    #1 rst_n = 1'b0;
    #1 chk("rst_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after");

    // NOP mode 7
    sb.push_back(idle_v(0));
    sb.push_back(ov(3'b110, 0, 0, 3'd5, 0, 0, 0, 0, 1, 1));
    sb.push_back(idle_v(0));
    cyc(1, 3'd7, 1, 0, "nop_start");
    cyc(0, 3'd7, 1, 0, "nop_cyc");
    cyc(0, 3'd7, 1, 0, "nop_idle");

    checks++;
    assert (sb.size() == 0) passed++;
    else $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
